// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin sequencer sharing one combinational 32x32 multiplier between two requesters.
// Optional feature macro MUL_ARB_STATS_EN enables per-requester completed-operation counters.
module mul_share_arbiter #(
  parameter int unsigned MUL_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        r0_req_valid,
  output logic        r0_req_ready,
  input  logic [31:0] r0_a,
  input  logic [31:0] r0_b,
  input  logic        r0_signed,
  output logic        r0_rsp_valid,
  input  logic        r0_rsp_ready,
  input  logic        r1_req_valid,
  output logic        r1_req_ready,
  input  logic [31:0] r1_a,
  input  logic [31:0] r1_b,
  input  logic        r1_signed,
  output logic        r1_rsp_valid,
  input  logic        r1_rsp_ready,
  output logic [63:0] rsp_product,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic        mul_signed,
  input  logic [63:0] mul_product,
  output logic [31:0] stat_cnt0,
  output logic [31:0] stat_cnt1
);
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state, state_nxt;
  logic          last;
  logic          owner;
  logic [CW-1:0] cnt;
  logic          gnt0_c, gnt1_c, capture_c, rsp_hs_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state plus grant/capture/handshake strobes; requester that is not 'last' wins a tie.
  always_comb begin
    state_nxt = state;
    gnt0_c    = 1'b0;
    gnt1_c    = 1'b0;
    capture_c = 1'b0;
    rsp_hs_c  = 1'b0;
    unique case (state)
      IDLE: begin
        if (r0_req_valid && (!r1_req_valid || last)) gnt0_c = 1'b1;
        else if (r1_req_valid)                       gnt1_c = 1'b1;
        if (gnt0_c || gnt1_c) state_nxt = WAIT;
      end
      WAIT: begin
        if (cnt == '0) begin
          capture_c = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        rsp_hs_c = owner ? (r1_rsp_valid && r1_rsp_ready) : (r0_rsp_valid && r0_rsp_ready);
        if (rsp_hs_c) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grants are combinational; forced low while reset is asserted.
  assign r0_req_ready = gnt0_c & rst_n;
  assign r1_req_ready = gnt1_c & rst_n;

  // Operand, settle counter and response registers; operands double as the multiplier drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last         <= 1'b1;
      owner        <= 1'b0;
      cnt          <= '0;
      mul_a        <= '0;
      mul_b        <= '0;
      mul_signed   <= 1'b0;
      rsp_product  <= '0;
      r0_rsp_valid <= 1'b0;
      r1_rsp_valid <= 1'b0;
    end else begin
      if (gnt0_c || gnt1_c) begin
        mul_a      <= gnt1_c ? r1_a : r0_a;
        mul_b      <= gnt1_c ? r1_b : r0_b;
        mul_signed <= gnt1_c ? r1_signed : r0_signed;
        owner      <= gnt1_c;
        last       <= gnt1_c;
        cnt        <= CW'(MUL_LAT - 1);
      end
      if (state == WAIT && !capture_c) cnt <= cnt - CW'(1);
      if (capture_c) begin
        rsp_product  <= mul_product;
        r0_rsp_valid <= ~owner;
        r1_rsp_valid <= owner;
      end
      if (rsp_hs_c) begin
        r0_rsp_valid <= 1'b0;
        r1_rsp_valid <= 1'b0;
      end
    end
  end

`ifdef MUL_ARB_STATS_EN
  // Completed-operation counters, wrapping at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_cnt0 <= '0;
      stat_cnt1 <= '0;
    end else if (rsp_hs_c) begin
      if (owner) stat_cnt1 <= stat_cnt1 + 32'd1;
      else       stat_cnt0 <= stat_cnt0 + 32'd1;
    end
  end
`else
  assign stat_cnt0 = '0;
  assign stat_cnt1 = '0;
`endif

endmodule
